tx_timestamp_inserter: RTL and testbench
========================================

Name: tx_timestamp_inserter

Overview:
- Sits directly downstream of the generator rate-limiting stage, between its master stream and the 10G TX path.
- Overwrites one 64-bit lane of a configurable packet word with a timestamp, so the receive side can measure latency.
- The timestamp is sampled when the packet's first word is accepted.
- One output register stage, full throughput; configured by software-driven register outputs from the wrapper.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output stream data width (multiple of 64).
- C_S_AXIS_DATA_WIDTH, 256, input stream data width (must equal C_M_AXIS_DATA_WIDTH).
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width.
- C_S_AXI_DATA_WIDTH, 32, width of the statistics counter.
- C_TS_WIDTH, 64, timestamp width (fixed at 64).

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  input stream from rate limiter.
- s_axis_tready  out  1  input backpressure.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  output stream to TX.
- m_axis_tready  in  1  downstream backpressure.
- sw_rst  in  1  synchronous software reset, active high.
- ts_en  in  1  enable stamping.
- ts_word_pos  in  8  zero-based beat index of the stamped word.
- ts_lane  in  2  64-bit lane within that beat; covers bits [64*ts_lane+63 : 64*ts_lane].
- stamp_counter  in  64  free-running time value from the timestamp unit.
- num_stamped  out  C_S_AXI_DATA_WIDTH  count of packets actually stamped.

Behaviour:
- Reset (axi_resetn=0, async) or sw_rst=1 (sync) clears:
  - m_axis_tvalid=0, m_axis_tdata/tstrb/tuser/tlast=0
  - num_stamped=0, beat counter=0, state=SOP, latched timestamp=0
  - s_axis_tready=1 one cycle after reset deasserts.
- Handshakes:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (registered-slice style; no combinational tvalid path).
  - Input accept = s_axis_tvalid && s_axis_tready; the beat appears on m_axis the next cycle (latency 1).
  - Output data is held stable while m_axis_tvalid && !m_axis_tready.
  - Back-to-back beats sustain 1 beat/cycle when m_axis_tready=1.
- State machine, two states:
  - SOP: waiting for the first beat. On accept:
    - latch stamp_counter into ts_hold; latch ts_en, ts_word_pos, ts_lane for this packet.
    - beat_cnt=1.
    - If tlast=1, stay in SOP; otherwise go to MID.
  - MID: on each accept, beat_cnt increments (8-bit, saturates at 255, no wrap). On tlast accept, return to SOP and set beat_cnt=0.
- Config timing: config changes mid-packet take effect at the next SOP only.
- Stamp rule, applied to the accepted beat whose index (0 for the SOP beat) equals the latched ts_word_pos, when latched ts_en=1:
  - If all 8 tstrb bits of the selected lane are 1: replace that lane's data with the timestamp. For the SOP beat this is the live stamp_counter; for later beats it is ts_hold. Mark the packet stamped.
  - If any strobe bit in the lane is 0: no overwrite, packet not stamped.
  - tstrb, tuser and tlast always pass unchanged.
- Short packet: if tlast arrives before beat ts_word_pos, nothing is stamped and the count does not change.
- num_stamped increments by 1 on the tlast accept of a stamped packet. It wraps at 2^C_S_AXI_DATA_WIDTH-1 → 0.
- sw_rst mid-packet: partial output is discarded (tvalid drops). The rest of the input packet is treated as a new packet starting at SOP. Software asserts sw_rst only while the stream is idle.
- sw_rst and an accept in the same cycle: sw_rst wins and the beat is dropped.

Test Plan:
- ts_en=1, ts_word_pos=0, ts_lane=0, stamp_counter=0x1122334455667788, 3-beat packet, all strobes set, tready=1 → beat0 bits[63:0]=0x1122334455667788, other bits unchanged; beats 1-2 unchanged; num_stamped=1; output 1 cycle after input.
- ts_word_pos=2, ts_lane=3, counter incrementing by 1 per cycle, SOP accepted at counter=0x100 → beat2 bits[255:192]=0x100 (latched at SOP, not the beat-2 time).
- ts_word_pos=4 with a 2-beat packet → output identical to input; num_stamped unchanged.
- Last beat tstrb=0x0000FFFF, ts_word_pos=that beat, ts_lane=2 → no overwrite; num_stamped unchanged.
- m_axis_tready toggles 1,0,0,1 during a 4-beat packet → s_axis_tready low while output is stalled; m_axis_tdata stable; no beat lost or duplicated; stamp correct.
- ts_en=0 → bit-exact passthrough. ts_en set to 1 mid-packet → the current packet stays unstamped and the next packet is stamped. Async reset mid-packet → m_axis_tvalid=0 immediately and num_stamped=0.

Source files
------------

// File: rtl/tx_timestamp_inserter_if.sv
// AXI4-Stream style bundle used between the rate limiter, the timestamp
// inserter and the 10G TX path.
interface tx_timestamp_inserter_if #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (
    output tdata,
    output tstrb,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/tx_timestamp_inserter.sv
// TX timestamp inserter: overwrites one 64-bit lane of a selected packet
// beat with the time sampled when the packet's first beat was accepted.
// Single registered output stage, full throughput.
module tx_timestamp_inserter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_TS_WIDTH           = 64
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  tx_timestamp_inserter_if.slave        s_axis,
  tx_timestamp_inserter_if.master       m_axis,
  input  logic                          sw_rst,
  input  logic                          ts_en,
  input  logic [7:0]                    ts_word_pos,
  input  logic [1:0]                    ts_lane,
  input  logic [C_TS_WIDTH-1:0]         stamp_counter,
  output logic [C_S_AXI_DATA_WIDTH-1:0] num_stamped
);

  localparam int unsigned LANE_W    = 64;
  localparam int unsigned NUM_LANES = C_M_AXIS_DATA_WIDTH / LANE_W;
  localparam int unsigned M_STRB_W  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned S_STRB_W  = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic {
    S_SOP,
    S_MID
  } state_t;

  // Input stream views
  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_data;
  logic [S_STRB_W-1:0]             s_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_user;
  logic                            s_last;
  logic                            s_ready;
  logic                            accept;

  // Registered output slice
  logic [C_M_AXIS_DATA_WIDTH-1:0]  m_data_q;
  logic [M_STRB_W-1:0]             m_strb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] m_user_q;
  logic                            m_last_q;
  logic                            m_valid_q;

  // Packet state and per-packet configuration snapshot
  state_t                          state;
  logic [7:0]                      beat_cnt;
  logic [C_TS_WIDTH-1:0]           ts_hold;
  logic                            en_q;
  logic [7:0]                      pos_q;
  logic [1:0]                      lane_q;
  logic                            target_seen_q;
  logic                            pkt_stamped_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   num_stamped_q;
  logic                            rdy_en_q;

  // Effective values for the beat currently offered on s_axis
  logic [7:0]                      cur_idx;
  logic                            cur_en;
  logic [7:0]                      cur_pos;
  logic [1:0]                      cur_lane;
  logic [C_TS_WIDTH-1:0]           cur_ts;
  logic                            hit;
  logic                            lane_full;
  logic                            do_stamp;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  out_data;

  assign s_data = s_axis.tdata;
  assign s_strb = s_axis.tstrb;
  assign s_user = s_axis.tuser;
  assign s_last = s_axis.tlast;

  // Slice-style backpressure: accept whenever the output register is free or draining
  assign s_ready       = rdy_en_q && (!m_valid_q || m_axis.tready);
  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid && s_ready;

  assign m_axis.tdata  = m_data_q;
  assign m_axis.tstrb  = m_strb_q;
  assign m_axis.tuser  = m_user_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tvalid = m_valid_q;
  assign num_stamped   = num_stamped_q;

  // Select config/timestamp source and build the possibly-stamped beat.
  // The SOP beat uses the live inputs since the snapshot registers are only
  // loaded on that same edge; target_seen_q stops a saturated beat counter
  // from matching the target position more than once.
  always_comb begin
    cur_idx   = '0;
    cur_en    = ts_en;
    cur_pos   = ts_word_pos;
    cur_lane  = ts_lane;
    cur_ts    = stamp_counter;
    if (state == S_MID) begin
      cur_idx  = beat_cnt;
      cur_en   = en_q;
      cur_pos  = pos_q;
      cur_lane = lane_q;
      cur_ts   = ts_hold;
    end
    hit       = cur_en && (cur_idx == cur_pos) && !((state == S_MID) && target_seen_q);
    lane_full = 1'b0;
    out_data  = s_data;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (32'(cur_lane) == i) begin
        lane_full = &s_strb[i*8 +: 8];
        if (hit && (&s_strb[i*8 +: 8])) begin
          out_data[i*LANE_W +: LANE_W] = cur_ts;
        end
      end
    end
    do_stamp = hit && lane_full;
  end

  // Output register slice, packet state machine and stamp bookkeeping
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rdy_en_q      <= 1'b0;
      state         <= S_SOP;
      beat_cnt      <= '0;
      ts_hold       <= '0;
      en_q          <= 1'b0;
      pos_q         <= '0;
      lane_q        <= '0;
      target_seen_q <= 1'b0;
      pkt_stamped_q <= 1'b0;
      num_stamped_q <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_strb_q      <= '0;
      m_user_q      <= '0;
      m_last_q      <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (sw_rst) begin
        state         <= S_SOP;
        beat_cnt      <= '0;
        ts_hold       <= '0;
        en_q          <= 1'b0;
        pos_q         <= '0;
        lane_q        <= '0;
        target_seen_q <= 1'b0;
        pkt_stamped_q <= 1'b0;
        num_stamped_q <= '0;
        m_valid_q     <= 1'b0;
        m_data_q      <= '0;
        m_strb_q      <= '0;
        m_user_q      <= '0;
        m_last_q      <= 1'b0;
      end else begin
        if (accept) begin
          m_valid_q <= 1'b1;
          m_data_q  <= out_data;
          m_strb_q  <= s_strb;
          m_user_q  <= s_user;
          m_last_q  <= s_last;
        end else if (m_axis.tready) begin
          m_valid_q <= 1'b0;
        end

        if (accept) begin
          case (state)
            S_SOP: begin
              ts_hold       <= stamp_counter;
              en_q          <= ts_en;
              pos_q         <= ts_word_pos;
              lane_q        <= ts_lane;
              target_seen_q <= hit;
              pkt_stamped_q <= do_stamp;
              if (s_last) begin
                beat_cnt <= '0;
                if (do_stamp) begin
                  num_stamped_q <= num_stamped_q + C_S_AXI_DATA_WIDTH'(1);
                end
              end else begin
                beat_cnt <= 8'd1;
                state    <= S_MID;
              end
            end
            S_MID: begin
              target_seen_q <= target_seen_q || hit;
              pkt_stamped_q <= pkt_stamped_q || do_stamp;
              if (s_last) begin
                beat_cnt <= '0;
                state    <= S_SOP;
                if (pkt_stamped_q || do_stamp) begin
                  num_stamped_q <= num_stamped_q + C_S_AXI_DATA_WIDTH'(1);
                end
              end else if (beat_cnt != 8'hFF) begin
                beat_cnt <= beat_cnt + 8'd1;
              end
            end
            default: state <= S_SOP;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_timestamp_inserter.sv
// Self-checking bench for tx_timestamp_inserter: directed scenarios plus a
// randomized packet mix, compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_tx_timestamp_inserter;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_rst;
  logic          ts_en;
  logic [7:0]    ts_word_pos;
  logic [1:0]    ts_lane;
  logic [63:0]   stamp_counter;
  logic [SW-1:0] num_stamped;

  always #5 clk = ~clk;

  tx_timestamp_inserter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  tx_timestamp_inserter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  tx_timestamp_inserter #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .C_S_AXI_DATA_WIDTH  (SW),
    .C_TS_WIDTH          (64)
  ) dut (
    .axi_aclk     (clk),
    .axi_resetn   (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .sw_rst       (sw_rst),
    .ts_en        (ts_en),
    .ts_word_pos  (ts_word_pos),
    .ts_lane      (ts_lane),
    .stamp_counter(stamp_counter),
    .num_stamped  (num_stamped)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic [UW-1:0]   user;
    logic            last;
    int              acc_cyc;
    bit              lat_chk;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] in_log[$];
  logic [DW-1:0] out_log[$];
  bit            pat_q[$];

  int  errors   = 0;
  int  checks   = 0;
  int  cyc      = 0;
  int  rdy_mode = 0;
  bit  mon_en   = 0;
  bit  prev_stall = 0;
  bit  acc      = 0;
  bit  cnt_inc  = 0;
  bit  gaps     = 0;
  logic [DW-1:0] prev_data;

  // Reference model state: per-packet beat index and SOP snapshot
  int            m_idx = 0;
  bit            m_en  = 0;
  bit            m_st  = 0;
  int            m_pos = 0;
  int            m_lane = 0;
  logic [63:0]   m_ts  = '0;
  logic [SW-1:0] exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: time and config are captured at the first beat;
  // the beat at the chosen index gets its lane replaced if fully strobed.
  task automatic model_accept(input beat_t b);
    beat_t o;
    if (m_idx == 0) begin
      m_en   = ts_en;
      m_pos  = int'(ts_word_pos);
      m_lane = int'(ts_lane);
      m_ts   = stamp_counter;
      m_st   = 0;
    end
    o = b;
    if (m_en && (m_idx == m_pos) && (b.strb[m_lane*8 +: 8] == 8'hFF)) begin
      o.data[m_lane*64 +: 64] = m_ts;
      m_st = 1;
    end
    o.acc_cyc = cyc;
    o.lat_chk = (rdy_mode == 0) && (pat_q.size() == 0);
    exp_q.push_back(o);
    in_log.push_back(b.data);
    if (b.last) begin
      if (m_st) exp_count = exp_count + 1;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic step();
    beat_t b;
    @(negedge clk);
    acc = 0;
    if (rst_n && !sw_rst && s_if.tvalid && s_if.tready) begin
      acc    = 1;
      b.data = s_if.tdata;
      b.strb = s_if.tstrb;
      b.user = s_if.tuser;
      b.last = s_if.tlast;
      b.acc_cyc = 0;
      b.lat_chk = 0;
      model_accept(b);
    end
    @(posedge clk);
    #1;
    if (cnt_inc) stamp_counter = stamp_counter + 64'd1;
    if (pat_q.size() > 0) m_if.tready = pat_q.pop_front();
    else if (rdy_mode == 1) m_if.tready = ($urandom_range(0, 3) != 0);
    else m_if.tready = 1'b1;
  endtask

  task automatic send_pkt(input int nb, input bit close, input logic [DW/8-1:0] last_strb,
                          input int en_flip_at);
    for (int i = 0; i < nb; i++) begin
      int guard;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_if.tvalid = 1'b0;
        step();
      end
      for (int w = 0; w < int'(DW / 32); w++) s_if.tdata[w*32 +: 32] = $urandom;
      for (int w = 0; w < int'(UW / 32); w++) s_if.tuser[w*32 +: 32] = $urandom;
      s_if.tstrb  = (i == nb - 1) ? last_strb : '1;
      s_if.tlast  = close && (i == nb - 1);
      s_if.tvalid = 1'b1;
      guard = 0;
      do begin
        step();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) chk("accept_timeout", acc, 1);
      if (i == en_flip_at) ts_en = 1'b1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && guard < 300) begin
      step();
      guard++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_num_stamped"}, num_stamped, exp_count);
  endtask

  // Output monitor: scoreboard compare, hold-while-stalled and ready rule
  always @(negedge clk) begin
    beat_t e;
    if (mon_en && rst_n) begin
      chk("s_tready_rule", s_if.tready, !m_if.tvalid || m_if.tready);
      if (prev_stall) begin
        chk("hold_valid", m_if.tvalid, 1);
        chk("hold_data", m_if.tdata, prev_data);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_if.tdata, e.data);
          chk("out_strb", m_if.tstrb, e.strb);
          chk("out_user", m_if.tuser, e.user);
          chk("out_last", m_if.tlast, e.last);
          if (e.lat_chk) chk("latency", cyc, e.acc_cyc + 1);
          out_log.push_back(m_if.tdata);
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    rst_n         = 1'b0;
    sw_rst        = 1'b0;
    ts_en         = 1'b0;
    ts_word_pos   = '0;
    ts_lane       = '0;
    stamp_counter = '0;
    s_if.tvalid   = 1'b0;
    s_if.tdata    = '0;
    s_if.tstrb    = '0;
    s_if.tuser    = '0;
    s_if.tlast    = 1'b0;
    m_if.tready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, '0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_num_stamped", num_stamped, 0);
    chk("rst_s_tready", s_if.tready, 0);
    rst_n = 1'b1;
    #2;
    chk("rdy_before_edge", s_if.tready, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", s_if.tready, 1);
    mon_en = 1;

    // Lane 0 of the SOP beat, fixed counter
    in_log.delete(); out_log.delete();
    ts_en = 1'b1; ts_word_pos = 8'd0; ts_lane = 2'd0;
    stamp_counter = 64'h1122334455667788;
    send_pkt(3, 1, '1, -1);
    drain("t1");
    chk("t1_lane0", out_log[0][63:0], 64'h1122334455667788);
    chk("t1_upper", out_log[0][255:64], in_log[0][255:64]);
    chk("t1_beat1", out_log[1], in_log[1]);
    chk("t1_beat2", out_log[2], in_log[2]);
    chk("t1_count", num_stamped, 1);

    // Later beat uses the SOP-time value, not the time of that beat
    in_log.delete(); out_log.delete();
    cnt_inc = 1; stamp_counter = 64'h100;
    ts_word_pos = 8'd2; ts_lane = 2'd3;
    send_pkt(4, 1, '1, -1);
    drain("t2");
    chk("t2_lane3", out_log[2][255:192], 64'h100);
    chk("t2_lower", out_log[2][191:0], in_log[2][191:0]);
    chk("t2_count", num_stamped, 2);

    // Short packet: target beat never arrives
    in_log.delete(); out_log.delete();
    ts_word_pos = 8'd4; ts_lane = 2'd1;
    send_pkt(2, 1, '1, -1);
    drain("t3");
    chk("t3_beat0", out_log[0], in_log[0]);
    chk("t3_beat1", out_log[1], in_log[1]);
    chk("t3_count", num_stamped, 2);

    // Partially strobed lane is left alone
    in_log.delete(); out_log.delete();
    ts_word_pos = 8'd2; ts_lane = 2'd2;
    send_pkt(3, 1, 32'h0000FFFF, -1);
    drain("t4");
    chk("t4_beat2", out_log[2], in_log[2]);
    chk("t4_count", num_stamped, 2);

    // Downstream stall pattern 1,0,0,1
    in_log.delete(); out_log.delete();
    ts_word_pos = 8'd1; ts_lane = 2'd1;
    pat_q.push_back(0); pat_q.push_back(0); pat_q.push_back(1);
    send_pkt(4, 1, '1, -1);
    drain("t5");
    chk("t5_beats", out_log.size(), 4);
    chk("t5_count", num_stamped, 3);

    // Disabled: bit-exact passthrough
    in_log.delete(); out_log.delete();
    ts_en = 1'b0; ts_word_pos = 8'd0; ts_lane = 2'd0;
    send_pkt(2, 1, '1, -1);
    drain("t6a");
    chk("t6_pass0", out_log[0], in_log[0]);
    chk("t6_pass1", out_log[1], in_log[1]);

    // Enable raised mid-packet only affects the following packet
    in_log.delete(); out_log.delete();
    ts_word_pos = 8'd1;
    send_pkt(3, 1, '1, 0);
    send_pkt(2, 1, '1, -1);
    drain("t6b");
    chk("t6_unstamped", out_log[1], in_log[1]);
    chk("t6_count", num_stamped, 4);

    // Randomized packet mix with gaps and random backpressure
    gaps = 1; rdy_mode = 1;
    for (int p = 0; p < 24; p++) begin
      logic [DW/8-1:0] ls;
      ts_en       = ($urandom_range(0, 3) != 0);
      ts_word_pos = 8'($urandom_range(0, 5));
      ts_lane     = 2'($urandom_range(0, 3));
      ls          = '1;
      if ($urandom_range(0, 3) == 0) ls = {$urandom, $urandom};
      send_pkt(int'($urandom_range(1, 6)), 1, ls, -1);
    end
    drain("rand");
    gaps = 0; rdy_mode = 0;

    // Software reset while idle clears the count
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    exp_count = '0;
    step();
    chk("swrst_count", num_stamped, 0);
    ts_en = 1'b1; ts_word_pos = 8'd0; ts_lane = 2'd2;
    send_pkt(1, 1, '1, -1);
    drain("swrst_after");

    // Asynchronous reset in the middle of a packet
    ts_word_pos = 8'd0; ts_lane = 2'd0;
    send_pkt(2, 0, '1, -1);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", m_if.tvalid, 0);
    chk("arst_num_stamped", num_stamped, 0);
    exp_q.delete();
    exp_count = '0;
    m_idx = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready", s_if.tready, 1);
    mon_en = 1;
    send_pkt(2, 1, '1, -1);
    drain("arst_after");
    chk("arst_count", num_stamped, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
